// File: rtl/pipeline_scoreboard_pkg.sv
// Shared pipeline definitions: forwarding-select encodings and the in-flight slot record.
package pipeline_scoreboard_pkg;

   localparam int unsigned REG_AW_MAX = 8;

   // Operand source select: 0 = register file, k+1 = in-flight slot k
   localparam int unsigned FWD_RF    = 0;
   localparam int unsigned FWD_SLOT0 = 1;

   typedef struct packed {
      logic                  valid;
      logic                  is_load;
      logic [REG_AW_MAX-1:0] rd;
   } slot_t;

   function automatic logic slot_writes(input slot_t s);
      return s.valid && (s.rd != '0);
   endfunction

endpackage

// File: rtl/pipeline_scoreboard_if.sv
// Issue-stage request and hazard/forwarding response bundle for the scoreboard.
interface pipeline_scoreboard_if #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned DEPTH  = 3,
   parameter int unsigned CNT_W  = 16
);
   localparam int unsigned FW_W = $clog2(DEPTH + 1);

   logic              issue_valid_i;
   logic [REG_AW-1:0] issue_rs_i;
   logic [REG_AW-1:0] issue_rt_i;
   logic              issue_rs_used_i;
   logic              issue_rt_used_i;
   logic [REG_AW-1:0] issue_rd_i;
   logic              issue_regwrite_i;
   logic              issue_is_load_i;
   logic              flush_i;

   logic              stall_o;
   logic              issue_fire_o;
   logic [FW_W-1:0]   fwd_a_o;
   logic [FW_W-1:0]   fwd_b_o;
   logic [FW_W-1:0]   inflight_o;
   logic [CNT_W-1:0]  stall_cnt_o;

   modport master (
      output issue_valid_i, issue_rs_i, issue_rt_i, issue_rs_used_i, issue_rt_used_i,
             issue_rd_i, issue_regwrite_i, issue_is_load_i, flush_i,
      input  stall_o, issue_fire_o, fwd_a_o, fwd_b_o, inflight_o, stall_cnt_o
   );

   modport slave (
      input  issue_valid_i, issue_rs_i, issue_rt_i, issue_rs_used_i, issue_rt_used_i,
             issue_rd_i, issue_regwrite_i, issue_is_load_i, flush_i,
      output stall_o, issue_fire_o, fwd_a_o, fwd_b_o, inflight_o, stall_cnt_o
   );
endinterface

// File: rtl/pipeline_scoreboard_match.sv
// Priority match of one source register against the in-flight slots; youngest producer wins.
module pipeline_scoreboard_match
   import pipeline_scoreboard_pkg::*;
#(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned DEPTH  = 3,
   parameter int unsigned FW_W   = 2
) (
   input  logic [REG_AW-1:0]  src,
   input  logic               src_used,
   input  slot_t [DEPTH-1:0]  slots,
   output logic               hit,
   output logic [FW_W-1:0]    index,
   output logic               is_load
);

   always_comb begin
      int unsigned k;
      hit     = 1'b0;
      index   = '0;
      is_load = 1'b0;
      k       = 0;
      // Scan oldest to youngest so the lowest matching slot is the last to write
      for (int unsigned j = 0; j < DEPTH; j++) begin
         k = DEPTH - 1 - j;
         if (src_used && (src != '0) && slot_writes(slots[k]) &&
             (slots[k].rd == REG_AW_MAX'(src))) begin
            hit     = 1'b1;
            index   = FW_W'(k);
            is_load = slots[k].is_load;
         end
      end
   end

endmodule

// File: rtl/pipeline_scoreboard.sv
// In-order issue scoreboard: tracks in-flight writers, selects forwarding sources, stalls on load-use.
module pipeline_scoreboard
   import pipeline_scoreboard_pkg::*;
#(
   parameter int unsigned REG_AW     = 5,
   parameter int unsigned DEPTH      = 3,
   parameter int unsigned LOAD_READY = 1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   pipeline_scoreboard_if.slave bus
);

   localparam int unsigned FW_W = $clog2(DEPTH + 1);

   slot_t [DEPTH-1:0] slots;
   slot_t             issue_slot;
   logic [CNT_W-1:0]  stall_cnt;
   logic [FW_W-1:0]   inflight;

   logic              hit_a, hit_b, load_a, load_b;
   logic [FW_W-1:0]   idx_a, idx_b;
   logic              hazard, stall, fire;
   logic [FW_W-1:0]   fwd_a, fwd_b;

   pipeline_scoreboard_match #(
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH),
      .FW_W   (FW_W)
   ) u_match_rs (
      .src      (bus.issue_rs_i),
      .src_used (bus.issue_rs_used_i),
      .slots    (slots),
      .hit      (hit_a),
      .index    (idx_a),
      .is_load  (load_a)
   );

   pipeline_scoreboard_match #(
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH),
      .FW_W   (FW_W)
   ) u_match_rt (
      .src      (bus.issue_rt_i),
      .src_used (bus.issue_rt_used_i),
      .slots    (slots),
      .hit      (hit_b),
      .index    (idx_b),
      .is_load  (load_b)
   );

   always_comb begin
      hazard = (hit_a && load_a && (32'(idx_a) < LOAD_READY)) ||
               (hit_b && load_b && (32'(idx_b) < LOAD_READY));
      stall  = bus.issue_valid_i & hazard & ~bus.flush_i;
      fire   = bus.issue_valid_i & ~stall & ~bus.flush_i;
      fwd_a  = FW_W'(FWD_RF);
      fwd_b  = FW_W'(FWD_RF);
      if (bus.issue_valid_i && hit_a) fwd_a = idx_a + FW_W'(FWD_SLOT0);
      if (bus.issue_valid_i && hit_b) fwd_b = idx_b + FW_W'(FWD_SLOT0);
   end

   // Non-writing instructions still occupy a slot but carry rd=0 so they never match
   always_comb begin
      issue_slot         = '0;
      issue_slot.valid   = 1'b1;
      issue_slot.is_load = bus.issue_is_load_i;
      issue_slot.rd      = bus.issue_regwrite_i ? REG_AW_MAX'(bus.issue_rd_i) : '0;
   end

   always_comb begin
      inflight = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         inflight = inflight + FW_W'(slots[i].valid);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         slots     <= '0;
         stall_cnt <= '0;
      end else begin
         for (int unsigned k = 1; k < DEPTH; k++) begin
            slots[k] <= slots[k-1];
         end
         slots[0] <= fire ? issue_slot : '0;
         if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
         end
      end
   end

   assign bus.stall_o      = stall;
   assign bus.issue_fire_o = fire;
   assign bus.fwd_a_o      = fwd_a;
   assign bus.fwd_b_o      = fwd_b;
   assign bus.inflight_o   = inflight;
   assign bus.stall_cnt_o  = stall_cnt;

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed checks of forwarding, load-use stall, flush, r0, reset and counter saturation.
module tb_pipeline_scoreboard;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   pipeline_scoreboard_if #(.REG_AW(5), .DEPTH(3), .CNT_W(16)) bus ();
   pipeline_scoreboard_if #(.REG_AW(5), .DEPTH(3), .CNT_W(2))  bus_sat ();

   pipeline_scoreboard #(
      .REG_AW     (5),
      .DEPTH      (3),
      .LOAD_READY (1),
      .CNT_W      (16)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   pipeline_scoreboard #(
      .REG_AW     (5),
      .DEPTH      (3),
      .LOAD_READY (1),
      .CNT_W      (2)
   ) dut_sat (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus_sat)
   );

   // The saturating instance sees the same issue stream
   assign bus_sat.issue_valid_i    = bus.issue_valid_i;
   assign bus_sat.issue_rs_i       = bus.issue_rs_i;
   assign bus_sat.issue_rt_i       = bus.issue_rt_i;
   assign bus_sat.issue_rs_used_i  = bus.issue_rs_used_i;
   assign bus_sat.issue_rt_used_i  = bus.issue_rt_used_i;
   assign bus_sat.issue_rd_i       = bus.issue_rd_i;
   assign bus_sat.issue_regwrite_i = bus.issue_regwrite_i;
   assign bus_sat.issue_is_load_i  = bus.issue_is_load_i;
   assign bus_sat.flush_i          = bus.flush_i;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] rs, input logic rs_used, input logic [4:0] rt,
                        input logic rt_used, input logic [4:0] rd, input logic regwrite,
                        input logic is_load);
      bus.issue_valid_i    = 1'b1;
      bus.issue_rs_i       = rs;
      bus.issue_rs_used_i  = rs_used;
      bus.issue_rt_i       = rt;
      bus.issue_rt_used_i  = rt_used;
      bus.issue_rd_i       = rd;
      bus.issue_regwrite_i = regwrite;
      bus.issue_is_load_i  = is_load;
      #1;
   endtask

   task automatic idle();
      bus.issue_valid_i    = 1'b0;
      bus.issue_rs_i       = '0;
      bus.issue_rs_used_i  = 1'b0;
      bus.issue_rt_i       = '0;
      bus.issue_rt_used_i  = 1'b0;
      bus.issue_rd_i       = '0;
      bus.issue_regwrite_i = 1'b0;
      bus.issue_is_load_i  = 1'b0;
      bus.flush_i          = 1'b0;
      #1;
   endtask

   task automatic drain();
      repeat (3) begin
         idle();
         step();
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      idle();

      // In reset: empty scoreboard, a valid instruction still reports fire
      drive(5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b1);
      check_eq("rst_inflight", 32'(bus.inflight_o), 0);
      check_eq("rst_cnt", 32'(bus.stall_cnt_o), 0);
      check_eq("rst_stall", 32'(bus.stall_o), 0);
      check_eq("rst_fire", 32'(bus.issue_fire_o), 1);
      idle();
      step();
      rst = 1'b0;
      step();
      check_eq("post_rst_inflight", 32'(bus.inflight_o), 0);

      // ALU back-to-back: add r8, then consumer of r8 from slot 0
      drive(5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0);
      check_eq("alu_fire0", 32'(bus.issue_fire_o), 1);
      check_eq("alu_fwd_a0", 32'(bus.fwd_a_o), 0);
      step();
      idle();
      bus.issue_rs_i      = 5'd8;
      bus.issue_rs_used_i = 1'b1;
      #1;
      check_eq("novalid_fwd_a", 32'(bus.fwd_a_o), 0);
      drive(5'd8, 1'b1, 5'd3, 1'b1, 5'd10, 1'b1, 1'b0);
      check_eq("alu_fwd_a", 32'(bus.fwd_a_o), 1);
      check_eq("alu_fwd_b", 32'(bus.fwd_b_o), 0);
      check_eq("alu_stall", 32'(bus.stall_o), 0);
      check_eq("alu_fire", 32'(bus.issue_fire_o), 1);
      check_eq("alu_inflight", 32'(bus.inflight_o), 1);
      step();

      // Load-use: lw r9, then consumer of r9 on rt stalls exactly one cycle
      drive(5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
      check_eq("lw_fire", 32'(bus.issue_fire_o), 1);
      step();
      drive(5'd4, 1'b1, 5'd9, 1'b1, 5'd11, 1'b1, 1'b0);
      check_eq("lu_stall", 32'(bus.stall_o), 1);
      check_eq("lu_nofire", 32'(bus.issue_fire_o), 0);
      step();
      check_eq("lu_stall_end", 32'(bus.stall_o), 0);
      check_eq("lu_fwd_b", 32'(bus.fwd_b_o), 2);
      check_eq("lu_fire", 32'(bus.issue_fire_o), 1);
      check_eq("lu_cnt", 32'(bus.stall_cnt_o), 1);
      check_eq("lu_inflight", 32'(bus.inflight_o), 2);
      step();
      drain();
      check_eq("drain_inflight", 32'(bus.inflight_o), 0);

      // Youngest wins: r5 in slots 0 and 2, r6 in slot 1
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      step();
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
      step();
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      step();
      drive(5'd5, 1'b1, 5'd6, 1'b1, 5'd12, 1'b1, 1'b0);
      check_eq("yw_fwd_a", 32'(bus.fwd_a_o), 1);
      check_eq("yw_fwd_b", 32'(bus.fwd_b_o), 2);
      check_eq("yw_stall", 32'(bus.stall_o), 0);
      check_eq("yw_inflight", 32'(bus.inflight_o), 3);
      step();
      drain();

      // r0: a load writing r0 neither forwards nor stalls
      drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
      step();
      drive(5'd0, 1'b1, 5'd0, 1'b1, 5'd13, 1'b1, 1'b0);
      check_eq("r0_fwd_a", 32'(bus.fwd_a_o), 0);
      check_eq("r0_fwd_b", 32'(bus.fwd_b_o), 0);
      check_eq("r0_stall", 32'(bus.stall_o), 0);
      check_eq("r0_fire", 32'(bus.issue_fire_o), 1);
      check_eq("r0_inflight", 32'(bus.inflight_o), 1);
      step();
      drain();

      // Flush overrides a load-use stall and inserts a bubble
      drive(5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
      step();
      bus.flush_i = 1'b1;
      drive(5'd4, 1'b1, 5'd9, 1'b1, 5'd11, 1'b1, 1'b0);
      check_eq("fl_stall", 32'(bus.stall_o), 0);
      check_eq("fl_fire", 32'(bus.issue_fire_o), 0);
      check_eq("fl_inflight0", 32'(bus.inflight_o), 1);
      step();
      check_eq("fl_bubble_fwd_b", 32'(bus.fwd_b_o), 2);
      check_eq("fl_bubble_fire", 32'(bus.issue_fire_o), 0);
      check_eq("fl_inflight1", 32'(bus.inflight_o), 1);
      idle();
      step();
      check_eq("fl_inflight2", 32'(bus.inflight_o), 1);
      step();
      check_eq("fl_inflight3", 32'(bus.inflight_o), 0);
      check_eq("fl_cnt", 32'(bus.stall_cnt_o), 1);

      // Four more load-use stalls: five stall cycles in total
      repeat (4) begin
         drive(5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
         step();
         drive(5'd4, 1'b1, 5'd9, 1'b1, 5'd11, 1'b1, 1'b0);
         check_eq("rep_stall", 32'(bus.stall_o), 1);
         step();
         check_eq("rep_fire", 32'(bus.issue_fire_o), 1);
         step();
         drain();
      end
      check_eq("cnt_total", 32'(bus.stall_cnt_o), 5);
      check_eq("cnt_sat", 32'(bus_sat.stall_cnt_o), 3);

      // Reset mid-stall clears state immediately; held instruction fires with fwd=0 after release
      drive(5'd1, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
      step();
      drive(5'd4, 1'b1, 5'd9, 1'b1, 5'd11, 1'b1, 1'b0);
      check_eq("rms_stall", 32'(bus.stall_o), 1);
      rst = 1'b1;
      #1;
      check_eq("rms_inflight", 32'(bus.inflight_o), 0);
      check_eq("rms_cnt", 32'(bus.stall_cnt_o), 0);
      check_eq("rms_cnt_sat", 32'(bus_sat.stall_cnt_o), 0);
      check_eq("rms_stall_rst", 32'(bus.stall_o), 0);
      check_eq("rms_fire_rst", 32'(bus.issue_fire_o), 1);
      step();
      rst = 1'b0;
      #1;
      check_eq("rms_rel_fire", 32'(bus.issue_fire_o), 1);
      check_eq("rms_rel_fwd_b", 32'(bus.fwd_b_o), 0);
      check_eq("rms_rel_stall", 32'(bus.stall_o), 0);
      step();
      idle();
      check_eq("rms_inflight_after", 32'(bus.inflight_o), 1);
      check_eq("rms_cnt_after", 32'(bus.stall_cnt_o), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pipeline_scoreboard.md
PIPELINE_SCOREBOARD -- requirements
Module: pipeline_scoreboard

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, meaning register-address width.
REQ-002 The block SHALL have parameter DEPTH, default 3, meaning tracked in-flight stages after issue (slot 0 = EX, slot 1 = MEM, slot DEPTH-1 = WB).
REQ-003 The block SHALL have parameter LOAD_READY, default 1, meaning the lowest slot index whose load result is forwardable.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning stall-counter width; derived FW_W = clog2(DEPTH+1).
REQ-005 The block SHALL have one clock and an asynchronous, active-high reset: clk_i  in  1  clock; rst_i  in  1  asynchronous active-high reset.
REQ-006 The block SHALL have these ports: issue_valid_i in 1, instruction present in ID; issue_rs_i / issue_rt_i in REG_AW, source addresses; issue_rs_used_i / issue_rt_used_i in 1, source read flags; issue_rd_i in REG_AW, destination; issue_regwrite_i in 1; issue_is_load_i in 1; flush_i in 1, discard ID instruction.
REQ-007 The block SHALL have these outputs: stall_o out 1, hold PC and IF/ID; issue_fire_o out 1, ID instruction enters EX; fwd_a_o / fwd_b_o out FW_W, operand source select; inflight_o out FW_W, count of valid slots; stall_cnt_o out CNT_W, saturating stall-cycle count.

Function
REQ-008 Each slot SHALL hold valid, rd, and is_load; a slot writes a register only if valid and rd != 0.
REQ-009 Each clock, slot[k] SHALL take slot[k-1] for k=1..DEPTH-1; slot 0 SHALL take the issued instruction when issue_fire_o=1, otherwise a bubble (valid=0).
REQ-010 An instruction SHALL occupy slot 0 on the cycle after it fires, and leave the scoreboard DEPTH cycles after firing.
REQ-011 A source SHALL match slot k when the source is used, its address != 0, and it equals slot[k].rd of a writing slot.
REQ-012 fwd_x_o SHALL be k+1 for the lowest matching k (youngest producer wins), or 0 (register file) if there is no match.
REQ-013 fwd_x_o SHALL be 0 whenever issue_valid_i=0.
REQ-014 A load-use hazard SHALL exist when either source's selected producer has is_load=1 and k < LOAD_READY.
REQ-015 stall_o SHALL be issue_valid_i & hazard & ~flush_i, so flush overrides stall.
REQ-016 issue_fire_o SHALL be issue_valid_i & ~stall_o & ~flush_i.
REQ-017 stall_o, issue_fire_o, and fwd_x_o SHALL be combinational from inputs and slot state, with zero-cycle latency.
REQ-018 The stall counter SHALL increment on each cycle with stall_o=1 and saturate at 2^CNT_W-1.
REQ-019 inflight_o SHALL be the registered-state popcount of slot valid bits, in the range 0..DEPTH.
REQ-020 When one source matches two slots, the lowest k SHALL decide both fwd and hazard.
REQ-021 Source rd=0 matches SHALL never stall or forward.

Reset
REQ-022 rst_i asserted SHALL asynchronously clear all slot valid bits and stall_cnt_o.
REQ-023 While in reset, stall_o=0 and issue_fire_o SHALL follow REQ-016.
REQ-024 Reset mid-stall SHALL drop the stalled hazard; after release, the held instruction SHALL fire with fwd=0.

Structure
REQ-025 FW_W encoding constants (FWD_RF=0, FWD_SLOT0=1 ...) and the slot record layout SHALL live in the shared pipeline-definitions package used by the forwarding MUXes.
REQ-026 One sub-module, pipeline_scoreboard_match, SHALL implement the per-source priority match (outputs hit, index, is_load); it SHALL be instantiated twice (rs, rt).
REQ-027 The implementation SHALL contain no latches, and all sequential logic SHALL be on clk_i posedge and rst_i posedge.

Verification (DEPTH=3, LOAD_READY=1)
REQ-028 The bench SHALL check ALU back-to-back: fire add rd=8; next cycle issue rs=8 -> fwd_a_o=1, stall_o=0, fire=1.
REQ-029 The bench SHALL check load-use: fire lw rd=9; next cycle issue rt=9 used -> stall_o=1 for exactly 1 cycle, then fwd_b_o=2, fire=1, stall_cnt_o=1.
REQ-030 The bench SHALL check youngest-wins: consecutive writes to r5 at slots 0 and 2 (non-load) -> fwd_a_o=1.
REQ-031 The bench SHALL check r0: fire write rd=0; issue rs=0 -> fwd_a_o=0, stall_o=0.
REQ-032 The bench SHALL check flush over stall: load-use condition with flush_i=1 -> stall_o=0, fire=0, slot 0 bubble next cycle, inflight_o decrements as expected.
REQ-033 The bench SHALL check reset mid-stall and counter saturation: force CNT_W=2, 5 stall cycles -> stall_cnt_o=3; assert rst_i during stall -> inflight_o=0, stall_cnt_o=0 immediately.
